// File: rtl/lsu_pkg.sv
// Shared LSU constants and the write-back sequencer state encoding.
// The LSU top, the store buffer and the write-back sequencer all import these.
package lsu_pkg;
  localparam int ORAM_ADDR_W = 8;
  localparam int ORAM_DATA_W = 128;
  localparam int MXU_ROWS    = 16;
  localparam int WB_LEN_W    = 4;

  typedef enum logic {
    WB_IDLE  = 1'b0,
    WB_WRITE = 1'b1
  } wb_state_t;
endpackage

// File: rtl/oram_wb_sequencer_if.sv
// MXU capture side and ORAM write-port side of the write-back sequencer.
// master = MXU/LSU environment, slave = sequencer.
interface oram_wb_sequencer_if
  import lsu_pkg::*;
#(
  parameter int ROWS   = MXU_ROWS,
  parameter int DATA_W = ORAM_DATA_W,
  parameter int ADDR_W = ORAM_ADDR_W
);
  logic                   mxu_wb_vld;
  logic [ROWS*DATA_W-1:0] mxu_wb_data;
  logic [ADDR_W-1:0]      wb_base_addr;
  logic [WB_LEN_W-1:0]    wb_row_len;
  logic                   wb_row_dir;
  logic                   wb_mxu_rdy;
  logic                   wb_busy;
  logic                   wb_done;
  logic                   wb_drop;
  logic                   oram_wb_req;
  logic                   oram_wb_gnt;
  logic                   oram_wb_cen;
  logic                   oram_wb_wen;
  logic [ADDR_W-1:0]      oram_wb_addr;
  logic [DATA_W-1:0]      oram_wb_din;

  modport master (
    output mxu_wb_vld, mxu_wb_data, wb_base_addr, wb_row_len, wb_row_dir, oram_wb_gnt,
    input  wb_mxu_rdy, wb_busy, wb_done, wb_drop,
           oram_wb_req, oram_wb_cen, oram_wb_wen, oram_wb_addr, oram_wb_din
  );

  modport slave (
    input  mxu_wb_vld, mxu_wb_data, wb_base_addr, wb_row_len, wb_row_dir, oram_wb_gnt,
    output wb_mxu_rdy, wb_busy, wb_done, wb_drop,
           oram_wb_req, oram_wb_cen, oram_wb_wen, oram_wb_addr, oram_wb_din
  );
endinterface

// File: rtl/oram_wb_sequencer.sv
// Captures one MXU result block in a single cycle and drains it into ORAM,
// one row per granted cycle, with incrementing or decrementing addresses.
module oram_wb_sequencer
  import lsu_pkg::*;
#(
  parameter int ROWS   = MXU_ROWS,
  parameter int DATA_W = ORAM_DATA_W,
  parameter int ADDR_W = ORAM_ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  oram_wb_sequencer_if.slave  bus
);

  wb_state_t                   state;
  logic [WB_LEN_W-1:0]         row_cnt;
  logic [WB_LEN_W-1:0]         last_row;
  logic [ADDR_W-1:0]           base;
  logic                        dir;
  logic                        done;
  logic                        drop;
  logic [ROWS-1:0][DATA_W-1:0] row_buf;
  logic                        wr;
  logic [ADDR_W-1:0]           offs;

  // Row buffer has no reset: it is only read after a capture has filled it.
  always_ff @(posedge clk) begin
    if (state == WB_IDLE && bus.mxu_wb_vld) row_buf <= bus.mxu_wb_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WB_IDLE;
      row_cnt  <= '0;
      last_row <= '0;
      base     <= '0;
      dir      <= 1'b0;
      done     <= 1'b0;
      drop     <= 1'b0;
    end else begin
      done <= 1'b0;
      drop <= 1'b0;
      case (state)
        WB_IDLE: begin
          if (bus.mxu_wb_vld) begin
            base     <= bus.wb_base_addr;
            last_row <= bus.wb_row_len;
            dir      <= bus.wb_row_dir;
            row_cnt  <= '0;
            state    <= WB_WRITE;
          end
        end
        WB_WRITE: begin
          if (bus.mxu_wb_vld) drop <= 1'b1;
          if (bus.oram_wb_gnt) begin
            if (row_cnt == last_row) begin
              state <= WB_IDLE;
              done  <= 1'b1;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

  assign wr   = (state == WB_WRITE) && bus.oram_wb_gnt;
  assign offs = ADDR_W'(row_cnt);

  assign bus.wb_mxu_rdy   = (state == WB_IDLE);
  assign bus.wb_busy      = (state == WB_WRITE);
  assign bus.oram_wb_req  = (state == WB_WRITE);
  assign bus.wb_done      = done;
  assign bus.wb_drop      = drop;
  assign bus.oram_wb_cen  = wr;
  assign bus.oram_wb_wen  = wr;
  // Address arithmetic wraps modulo 2^ADDR_W in both directions.
  assign bus.oram_wb_addr = !wr ? '0 : (dir ? base + offs : base - offs);
  assign bus.oram_wb_din  = wr ? row_buf[row_cnt] : '0;

endmodule

// File: tb/tb_oram_wb_sequencer.sv
// Directed bench for oram_wb_sequencer: drain order, wrap, grant stalls,
// dropped captures and mid-drain reset.
module tb_oram_wb_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [15:0][127:0] data_a, data_b;

  always #5 clk = ~clk;

  oram_wb_sequencer_if #(.ROWS(16), .DATA_W(128), .ADDR_W(8)) bus ();

  oram_wb_sequencer #(.ROWS(16), .DATA_W(128), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_capture(input logic [15:0][127:0] d, input logic [7:0] b,
                               input logic [3:0] len, input logic dir);
    bus.mxu_wb_vld = 1'b1; bus.mxu_wb_data = d;
    bus.wb_base_addr = b; bus.wb_row_len = len; bus.wb_row_dir = dir;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.mxu_wb_vld = 1'b0; bus.oram_wb_gnt = 1'b0; bus.mxu_wb_data = '0;
    bus.wb_base_addr = '0; bus.wb_row_len = '0; bus.wb_row_dir = 1'b0;
    #3;
    checks++; if (bus.wb_mxu_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b want 1", bus.wb_mxu_rdy); end
    checks++; if (bus.wb_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.wb_busy); end
    checks++; if (bus.oram_wb_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", bus.oram_wb_req); end
    checks++; if (bus.wb_done !== 1'b0 || bus.wb_drop !== 1'b0) begin errors++; $display("FAIL reset_pulses got done=%b drop=%b want 0 0", bus.wb_done, bus.wb_drop); end
    checks++; if (bus.oram_wb_cen !== 1'b0 || bus.oram_wb_addr !== 8'h00) begin errors++; $display("FAIL reset_oram got cen=%b addr=%h want 0 00", bus.oram_wb_cen, bus.oram_wb_addr); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_inc16();
    logic [7:0] b;
    logic [127:0] exp;
    step();
    bus.oram_wb_gnt = 1'b1;
    drive_capture(data_a, 8'h10, 4'd15, 1'b1);
    #1;
    checks++; if (bus.oram_wb_cen !== 1'b0) begin errors++; $display("FAIL inc16_capture_cen got %b want 0", bus.oram_wb_cen); end
    for (int i = 0; i < 16; i++) begin
      step(); bus.mxu_wb_vld = 1'b0; #1;
      b = 8'(i); exp = {16{b}};
      checks++; if (bus.oram_wb_cen !== 1'b1 || bus.oram_wb_wen !== 1'b1) begin errors++; $display("FAIL inc16_en row %0d got cen=%b wen=%b want 1 1", i, bus.oram_wb_cen, bus.oram_wb_wen); end
      checks++; if (bus.oram_wb_addr !== 8'h10 + b) begin errors++; $display("FAIL inc16_addr row %0d got %h want %h", i, bus.oram_wb_addr, 8'h10 + b); end
      checks++; if (bus.oram_wb_din !== exp) begin errors++; $display("FAIL inc16_din row %0d got %h want %h", i, bus.oram_wb_din, exp); end
      checks++; if (bus.wb_busy !== 1'b1 || bus.wb_done !== 1'b0 || bus.wb_mxu_rdy !== 1'b0) begin errors++; $display("FAIL inc16_status row %0d got busy=%b done=%b rdy=%b want 1 0 0", i, bus.wb_busy, bus.wb_done, bus.wb_mxu_rdy); end
    end
    step(); #1;
    checks++; if (bus.wb_done !== 1'b1 || bus.wb_mxu_rdy !== 1'b1 || bus.oram_wb_cen !== 1'b0) begin errors++; $display("FAIL inc16_done got done=%b rdy=%b cen=%b want 1 1 0", bus.wb_done, bus.wb_mxu_rdy, bus.oram_wb_cen); end
    step(); #1;
    checks++; if (bus.wb_done !== 1'b0) begin errors++; $display("FAIL inc16_done_pulse got %b want 0", bus.wb_done); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_addr [4];
    exp_addr = '{8'h01, 8'h00, 8'hFF, 8'hFE};
    step();
    bus.oram_wb_gnt = 1'b1;
    drive_capture(data_b, 8'h01, 4'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(); bus.mxu_wb_vld = 1'b0; #1;
      checks++; if (bus.oram_wb_cen !== 1'b1 || bus.oram_wb_addr !== exp_addr[i]) begin errors++; $display("FAIL wrap_addr row %0d got cen=%b addr=%h want 1 %h", i, bus.oram_wb_cen, bus.oram_wb_addr, exp_addr[i]); end
      checks++; if (bus.oram_wb_din !== data_b[i]) begin errors++; $display("FAIL wrap_din row %0d got %h want %h", i, bus.oram_wb_din, data_b[i]); end
    end
    step(); #1;
    checks++; if (bus.wb_done !== 1'b1 || bus.wb_busy !== 1'b0) begin errors++; $display("FAIL wrap_done got done=%b busy=%b want 1 0", bus.wb_done, bus.wb_busy); end
  endtask

  task automatic test_gnt_toggle();
    logic [7:0] pat;
    int k;
    pat = 8'b1010_1001;  // bit c is gnt in drain cycle c: 1,0,0,1,0,1,0,1
    k = 0;
    step();
    bus.oram_wb_gnt = 1'b0;
    drive_capture(data_b, 8'h40, 4'd3, 1'b1);
    for (int c = 0; c < 20 && k < 4; c++) begin
      step(); bus.mxu_wb_vld = 1'b0;
      bus.oram_wb_gnt = (c < 8) ? pat[c] : 1'b1;
      #1;
      checks++; if (bus.oram_wb_cen !== bus.oram_wb_gnt || bus.oram_wb_req !== 1'b1) begin errors++; $display("FAIL toggle_cen cycle %0d got cen=%b req=%b want %b 1", c, bus.oram_wb_cen, bus.oram_wb_req, bus.oram_wb_gnt); end
      if (bus.oram_wb_gnt) begin
        checks++; if (bus.oram_wb_addr !== 8'h40 + 8'(k) || bus.oram_wb_din !== data_b[k]) begin errors++; $display("FAIL toggle_write %0d got addr=%h want %h", k, bus.oram_wb_addr, 8'h40 + 8'(k)); end
        k++;
      end
    end
    checks++; if (k != 4) begin errors++; $display("FAIL toggle_count got %0d writes want 4", k); end
    step(); #1;
    checks++; if (bus.wb_done !== 1'b1) begin errors++; $display("FAIL toggle_done got %b want 1", bus.wb_done); end
  endtask

  task automatic test_drop();
    step();
    bus.oram_wb_gnt = 1'b1;
    drive_capture(data_a, 8'h80, 4'd15, 1'b1);
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 3) drive_capture(data_b, 8'h00, 4'd0, 1'b0);
      else bus.mxu_wb_vld = 1'b0;
      #1;
      checks++; if (bus.wb_drop !== (c == 4)) begin errors++; $display("FAIL drop_pulse cycle T+%0d got %b want %b", c, bus.wb_drop, (c == 4)); end
      checks++; if (bus.oram_wb_addr !== 8'h80 + 8'(c - 1) || bus.oram_wb_din !== data_a[c-1]) begin errors++; $display("FAIL drop_data cycle T+%0d got addr=%h want %h", c, bus.oram_wb_addr, 8'h80 + 8'(c - 1)); end
    end
    step();
    drive_capture(data_b, 8'h20, 4'd1, 1'b1);
    #1;
    checks++; if (bus.wb_done !== 1'b1 || bus.wb_mxu_rdy !== 1'b1) begin errors++; $display("FAIL drop_done got done=%b rdy=%b want 1 1", bus.wb_done, bus.wb_mxu_rdy); end
    for (int i = 0; i < 2; i++) begin
      step(); bus.mxu_wb_vld = 1'b0; #1;
      checks++; if (bus.oram_wb_cen !== 1'b1 || bus.oram_wb_addr !== 8'h20 + 8'(i) || bus.oram_wb_din !== data_b[i]) begin errors++; $display("FAIL drop_next row %0d got cen=%b addr=%h want 1 %h", i, bus.oram_wb_cen, bus.oram_wb_addr, 8'h20 + 8'(i)); end
    end
    step(); #1;
    checks++; if (bus.wb_done !== 1'b1) begin errors++; $display("FAIL drop_next_done got %b want 1", bus.wb_done); end
  endtask

  task automatic test_reset_mid();
    step();
    bus.oram_wb_gnt = 1'b1;
    drive_capture(data_a, 8'h10, 4'd15, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      step(); bus.mxu_wb_vld = 1'b0;
    end
    step(); rst_n = 1'b0; #1;
    checks++; if (bus.oram_wb_req !== 1'b0 || bus.oram_wb_cen !== 1'b0 || bus.oram_wb_wen !== 1'b0) begin errors++; $display("FAIL rst_mid_port got req=%b cen=%b wen=%b want 0 0 0", bus.oram_wb_req, bus.oram_wb_cen, bus.oram_wb_wen); end
    checks++; if (bus.wb_busy !== 1'b0 || bus.wb_mxu_rdy !== 1'b1) begin errors++; $display("FAIL rst_mid_status got busy=%b rdy=%b want 0 1", bus.wb_busy, bus.wb_mxu_rdy); end
    @(negedge clk); rst_n = 1'b1;
    step();
    drive_capture(data_b, 8'h30, 4'd0, 1'b1);
    step(); bus.mxu_wb_vld = 1'b0; #1;
    checks++; if (bus.oram_wb_cen !== 1'b1 || bus.oram_wb_addr !== 8'h30 || bus.oram_wb_din !== data_b[0]) begin errors++; $display("FAIL rst_mid_restart got cen=%b addr=%h want 1 30", bus.oram_wb_cen, bus.oram_wb_addr); end
    step(); #1;
    checks++; if (bus.wb_done !== 1'b1 || bus.wb_mxu_rdy !== 1'b1) begin errors++; $display("FAIL rst_mid_done got done=%b rdy=%b want 1 1", bus.wb_done, bus.wb_mxu_rdy); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      data_a[i] = {16{8'(i)}};
      data_b[i] = {4{32'hC0DE_0000 | 32'(i)}};
    end
    test_reset();
    test_inc16();
    test_wrap();
    test_gnt_toggle();
    test_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/oram_wb_sequencer.md
# oram_wb_sequencer

Write-back sequencer between the MXU result rows and the ORAM inside the LSU. On each MXU result-ready event it captures up to 16 int8 result rows of 128 bits in one cycle. It then drains them into ORAM one 128-bit entry per granted cycle, so the ORAM write port, currently tied off, gets a real producer. The LSU arbitrates that port against store-buffer reads through a simple req/gnt pair.

## Interface
Parameters:
- ROWS, 16, result rows per MXU event
- DATA_W, 128, bits per row / ORAM entry
- ADDR_W, 8, ORAM entry address width

Ports:
- clk  input  1  clock; all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- mxu_wb_vld  input  1  one-cycle pulse: result rows valid (driven from mxu_lsu_data_rdy)
- mxu_wb_data  input  ROWS*DATA_W  row i at bits [i*DATA_W +: DATA_W]
- wb_base_addr  input  ADDR_W  ORAM address of row 0, sampled with mxu_wb_vld
- wb_row_len  input  4  rows to write minus 1 (0..15 → 1..16 rows), sampled with mxu_wb_vld
- wb_row_dir  input  1  1: address increments per row; 0: decrements; sampled with mxu_wb_vld
- wb_mxu_rdy  output  1  sequencer idle, capture allowed
- wb_busy  output  1  rows pending
- wb_done  output  1  one-cycle pulse after the last row is written
- wb_drop  output  1  one-cycle pulse: mxu_wb_vld arrived while busy and was ignored
- oram_wb_req  output  1  requests the ORAM port this cycle
- oram_wb_gnt  input  1  LSU grants the ORAM port; combinational from req allowed
- oram_wb_cen  output  1  ORAM chip enable, active-high
- oram_wb_wen  output  1  ORAM write enable, active-high
- oram_wb_addr  output  ADDR_W  ORAM entry address
- oram_wb_din  output  DATA_W  ORAM write data

## Operation
- FSM states:
  - IDLE (reset state): wb_mxu_rdy=1, oram_wb_req=0.
  - WRITE: wb_busy=1, oram_wb_req=1.
- IDLE, mxu_wb_vld=1: capture mxu_wb_data into the row buffer (ROWS×DATA_W flops). Latch base address, last_row=wb_row_len and dir; clear row_cnt=0; go to WRITE.
- WRITE, oram_wb_gnt=0: outputs hold; cen=wen=0; no progress.
- WRITE, oram_wb_gnt=1: cen=wen=1, din=row[row_cnt], and:
  - addr = base+row_cnt when dir=1, base−row_cnt when dir=0, modulo 2^ADDR_W (wraps 255→0 and 0→255).
  - If row_cnt==last_row, go to IDLE and pulse wb_done next cycle. Otherwise row_cnt+1.
- oram_wb_cen = oram_wb_wen = (state==WRITE) & oram_wb_gnt, combinational. oram_wb_addr and oram_wb_din are don't-care when cen=0; drive 0.
- WRITE, mxu_wb_vld=1: ignored, row buffer untouched, wb_drop pulses the next cycle.
- The capture cycle ignores gnt; writes start at the earliest the following cycle.
- Reset mid-WRITE: FSM→IDLE, counters and flags cleared, remaining rows lost; the row buffer need not be cleared.
- Reset values: wb_mxu_rdy=1; all other outputs 0.

## Timing
- Capture at edge T (vld sampled) → WRITE from T; first write cycle T+1 when granted.
- With gnt held high, N=wb_row_len+1 rows are written in cycles T+1..T+N.
- wb_done is registered: high in cycle T+N+1, the same cycle wb_mxu_rdy returns to 1.
- Back-to-back: the next mxu_wb_vld is accepted at T+N+1. Minimum event period is N+1 cycles.
- Every cycle gnt is low adds one cycle; there is no timeout.
- wb_drop is registered, one cycle after the offending vld.

## Structure
- lsu_pkg holds ORAM_ADDR_W=8, ORAM_DATA_W=128, MXU_ROWS=16 and the FSM state encoding (IDLE=1'b0, WRITE=1'b1). The LSU, store_buffer and this block share them.
- Single module, no sub-module. State, counter and config registers use the existing DFFR/DFFE primitives. The row buffer is a DFFE array enabled on capture.
- The row mux is a ROWS:1 index on row_cnt.

## Test plan
- Capture with row_len=15, dir=1, base=0x10, gnt=1, row i data = {16{i[7:0]}} → 16 writes to addr 0x10..0x1F with matching data in T+1..T+16; wb_done at T+17; rdy high at T+17.
- Capture with row_len=3, dir=0, base=0x01 → writes to 0x01, 0x00, 0xFF, 0xFE (wrap-around); wb_done after 4 writes.
- gnt toggling 1,0,0,1,… during a 4-row drain → cen only in granted cycles; addresses strictly in sequence, none repeated or skipped.
- mxu_wb_vld pulsed at T+3 during a 16-row drain → wb_drop at T+4; remaining writes carry the original data; next vld after done is accepted.
- rst_n asserted at T+5 of a 16-row drain → req, cen, wen and busy are 0 immediately; rdy=1. A capture after reset release writes from row 0 of the new data.
